// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store unit with byte lanes, load extension and response timeout
// Issues data-memory requests, stalls until completion, and registers the load result for WB.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_MemRead,
  input  logic        i_MemWrite,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_storeData,
  input  logic [4:0]  i_rd,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_wstrb,
  input  logic        i_dmem_ready,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_stall,
  output logic        o_WB_loadValid,
  output logic [31:0] o_WB_loadValue,
  output logic [4:0]  o_WB_rd,
  output logic        o_fault
);

  typedef enum logic {IDLE, RESP} state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load_valid_q, load_valid_d;
  logic [31:0]   load_value_q, load_value_d;
  logic [4:0]    rd_q, rd_d;
  logic          fault_q, fault_d;

  logic        op, bad, f3_illegal, misaligned, store_unsigned, timeout_hit;
  logic [31:0] shifted, extracted;

  assign op             = i_MemRead | i_MemWrite;
  assign f3_illegal     = (i_funct3 == 3'b011) | (i_funct3[2:1] == 2'b11);
  assign misaligned     = ((i_funct3[1:0] == 2'b10) & (i_addr[1:0] != 2'b00)) |
                          ((i_funct3[1:0] == 2'b01) & i_addr[0]);
  assign store_unsigned = i_MemWrite & i_funct3[2];
  assign bad            = f3_illegal | misaligned | store_unsigned;

  // A zero TIMEOUT disables the abort entirely.
  assign timeout_hit = (TIMEOUT != 0) && (32'(cnt_q) == 32'(TIMEOUT - 1));

  assign o_dmem_addr = {i_addr[31:2], 2'b00};
  assign o_dmem_we   = i_MemWrite;
  assign o_dmem_req  = i_rst_n & (state_q == IDLE) & op & ~bad;

  always_comb begin
    o_stall = 1'b0;
    if (i_rst_n) begin
      if (state_q == IDLE) begin
        o_stall = op & ~bad & (i_MemRead | ~i_dmem_ready);
      end else begin
        o_stall = ~i_dmem_rvalid & ~timeout_hit;
      end
    end
  end

  always_comb begin
    o_dmem_wstrb = 4'b0000;
    o_dmem_wdata = i_storeData;
    case (i_funct3[1:0])
      2'b00: begin
        o_dmem_wstrb = 4'b0001 << i_addr[1:0];
        o_dmem_wdata = {4{i_storeData[7:0]}};
      end
      2'b01: begin
        o_dmem_wstrb = i_addr[1] ? 4'b1100 : 4'b0011;
        o_dmem_wdata = {2{i_storeData[15:0]}};
      end
      default: o_dmem_wstrb = 4'b1111;
    endcase
    if (!i_MemWrite) o_dmem_wstrb = 4'b0000;
  end

  assign shifted = i_dmem_rdata >> {i_addr[1:0], 3'b000};

  always_comb begin
    extracted = i_dmem_rdata;
    case (i_funct3)
      3'b000:  extracted = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  extracted = {24'b0, shifted[7:0]};
      3'b001:  extracted = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  extracted = {16'b0, shifted[15:0]};
      default: extracted = i_dmem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    load_valid_d = 1'b0;
    load_value_d = load_value_q;
    rd_d         = rd_q;
    fault_d      = 1'b0;
    if (state_q == IDLE) begin
      if (op && bad) begin
        fault_d = 1'b1;
      end else if (op && i_MemRead && i_dmem_ready) begin
        state_d = RESP;
        cnt_d   = '0;
      end
    end else begin
      // Data beats timeout when both arrive in the same cycle.
      if (i_dmem_rvalid) begin
        state_d      = IDLE;
        load_valid_d = 1'b1;
        load_value_d = extracted;
        rd_d         = i_rd;
      end else if (timeout_hit) begin
        state_d = IDLE;
        fault_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      load_valid_q <= 1'b0;
      load_value_q <= '0;
      rd_q         <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      load_valid_q <= load_valid_d;
      load_value_q <= load_value_d;
      rd_q         <= rd_d;
      fault_q      <= fault_d;
    end
  end

  assign o_WB_loadValid = load_valid_q;
  assign o_WB_loadValue = load_value_q;
  assign o_WB_rd        = rd_q;
  assign o_fault        = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized bench for load_store_unit against a transaction-level model
module tb_load_store_unit;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0, store_data = '0, rdata = '0;
  logic [4:0]  rd = '0;
  logic        ready = 1'b0, rvalid = 1'b0;
  logic        req, we, stall, lv, fault;
  logic [31:0] maddr, wdata, lval;
  logic [3:0]  wstrb;
  logic [4:0]  wb_rd;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(T)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_MemRead(mem_read), .i_MemWrite(mem_write),
    .i_funct3(funct3), .i_addr(addr), .i_storeData(store_data), .i_rd(rd),
    .o_dmem_req(req), .o_dmem_we(we), .o_dmem_addr(maddr), .o_dmem_wdata(wdata),
    .o_dmem_wstrb(wstrb), .i_dmem_ready(ready), .i_dmem_rvalid(rvalid),
    .i_dmem_rdata(rdata), .o_stall(stall), .o_WB_loadValid(lv),
    .o_WB_loadValue(lval), .o_WB_rd(wb_rd), .o_fault(fault)
  );

  int n_chk = 0, n_err = 0;
  logic chk_on = 1'b0;

  logic        exp_req = 0, exp_we = 0, exp_stall = 0, exp_lv = 0, exp_fault = 0;
  logic [31:0] exp_addr = 0, exp_wdata = 0, exp_val = 0;
  logic [3:0]  exp_wstrb = 0;
  logic [4:0]  exp_rd = 0;
  logic        nxt_lv = 0, nxt_fault = 0;
  logic [31:0] nxt_val = 0;
  logic [4:0]  nxt_rd = 0;
  logic [3:0]  cap_wstrb = 0;
  logic [31:0] cap_wdata = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_bad(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    int nbytes;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (wr && f3 >= 3'd4) return 1'b1;
    nbytes = 1 << f3[1:0];
    return (a % 32'(nbytes)) != 0;
  endfunction

  function automatic logic [3:0] strb_model(input logic [2:0] f3, input logic [31:0] a);
    int nbytes;
    nbytes = 1 << f3[1:0];
    return 4'(((1 << nbytes) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] wdata_model(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'd0:    return (d & 32'hFF) * 32'h01010101;
      2'd1:    return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] s;
    s = w >> (8 * a[1:0]);
    case (f3)
      3'd0:    return ((s & 32'hFF) ^ 32'h80) - 32'h80;
      3'd4:    return s & 32'hFF;
      3'd1:    return ((s & 32'hFFFF) ^ 32'h8000) - 32'h8000;
      3'd5:    return s & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      chk("req", 32'(req), 32'(exp_req));
      chk("stall", 32'(stall), 32'(exp_stall));
      if (exp_req) begin
        chk("we", 32'(we), 32'(exp_we));
        chk("addr", maddr, exp_addr);
        chk("wstrb", 32'(wstrb), 32'(exp_wstrb));
        if (exp_we) chk("wdata", wdata, exp_wdata);
      end
      chk("load_valid", 32'(lv), 32'(exp_lv));
      chk("fault", 32'(fault), 32'(exp_fault));
      chk("load_value", lval, exp_val);
      chk("wb_rd", 32'(wb_rd), 32'(exp_rd));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    exp_lv = nxt_lv;
    exp_fault = nxt_fault;
    if (nxt_lv) begin
      exp_val = nxt_val;
      exp_rd = nxt_rd;
    end
    nxt_lv = 1'b0;
    nxt_fault = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      mem_read = 1'b0;
      mem_write = 1'b0;
      ready = 1'($urandom);
      rvalid = 1'($urandom);
      rdata = $urandom;
      exp_req = 1'b0;
      exp_stall = 1'b0;
    end
  endtask

  // a = cycles with ready low before acceptance; L = RESP cycle in which rvalid arrives.
  task automatic do_op(input logic ld, input logic [2:0] f3, input logic [31:0] a_in,
                       input logic [31:0] d, input logic [4:0] rd_in, input int a,
                       input int L, input logic [31:0] rd_word);
    logic bad_op;
    bad_op = is_bad(~ld, f3, a_in);
    step();
    mem_read = ld;
    mem_write = ~ld;
    funct3 = f3;
    addr = a_in;
    store_data = d;
    rd = rd_in;
    rvalid = 1'b0;
    rdata = rd_word;
    exp_we = ~ld;
    exp_addr = a_in & ~32'h3;
    exp_wstrb = ld ? 4'b0000 : strb_model(f3, a_in);
    exp_wdata = wdata_model(f3, d);
    if (bad_op) begin
      ready = 1'($urandom);
      exp_req = 1'b0;
      exp_stall = 1'b0;
      nxt_fault = 1'b1;
      return;
    end
    for (int k = 0; k <= a; k++) begin
      if (k > 0) step();
      ready = (k == a);
      exp_req = 1'b1;
      exp_stall = ld || (k < a);
      if (k == a) begin
        @(negedge clk);
        cap_wstrb = wstrb;
        cap_wdata = wdata;
      end
    end
    if (!ld) return;
    for (int r = 1; r <= L; r++) begin
      step();
      ready = 1'($urandom);
      exp_req = 1'b0;
      rvalid = (r == L);
      if (r == L) begin
        exp_stall = 1'b0;
        nxt_lv = 1'b1;
        nxt_val = ld_model(f3, a_in, rd_word);
        nxt_rd = rd_in;
        break;
      end else if (r == T) begin
        exp_stall = 1'b0;
        nxt_fault = 1'b1;
        break;
      end
      exp_stall = 1'b1;
    end
  endtask

  initial begin
    #1;
    rst_n = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);
    chk("lit_reset_value", lval, 32'h0);
    chk("lit_reset_stall", 32'(stall), 32'h0);
    step();
    rst_n = 1'b1;
    idle(1);

    do_op(1'b0, 3'b010, 32'h104, 32'hDEADBEEF, 5'd0, 0, 0, 32'h0);
    chk("lit_sw_wstrb", 32'(cap_wstrb), 32'hF);
    do_op(1'b0, 3'b000, 32'h103, 32'h000000A5, 5'd0, 0, 0, 32'h0);
    chk("lit_sb_wstrb", 32'(cap_wstrb), 32'h8);
    chk("lit_sb_wdata", cap_wdata, 32'hA5A5A5A5);
    do_op(1'b0, 3'b001, 32'h102, 32'h00001234, 5'd0, 0, 0, 32'h0);
    chk("lit_sh_wstrb", 32'(cap_wstrb), 32'hC);
    chk("lit_sh_wdata", cap_wdata, 32'h12341234);

    do_op(1'b1, 3'b000, 32'h201, 32'h0, 5'd7, 0, 3, 32'h00008000);
    idle(1);
    @(negedge clk);
    chk("lit_lb_valid", 32'(lv), 32'h1);
    chk("lit_lb_value", lval, 32'hFFFFFF80);
    chk("lit_lb_rd", 32'(wb_rd), 32'd7);
    do_op(1'b1, 3'b100, 32'h201, 32'h0, 5'd7, 0, 3, 32'h00008000);
    idle(1);
    @(negedge clk);
    chk("lit_lbu_value", lval, 32'h00000080);

    do_op(1'b1, 3'b010, 32'h200, 32'h0, 5'd3, 2, 2, 32'h13579BDF);
    do_op(1'b0, 3'b010, 32'h300, 32'hCAFEF00D, 5'd0, 2, 0, 32'h0);

    do_op(1'b1, 3'b010, 32'h202, 32'h0, 5'd4, 0, 1, 32'h0);
    idle(1);
    @(negedge clk);
    chk("lit_lw_misaligned_fault", 32'(fault), 32'h1);
    do_op(1'b1, 3'b011, 32'h200, 32'h0, 5'd4, 0, 1, 32'h0);
    do_op(1'b1, 3'b001, 32'h201, 32'h0, 5'd4, 0, 1, 32'h0);
    idle(1);

    do_op(1'b1, 3'b010, 32'h400, 32'h0, 5'd5, 0, T + 2, 32'h0);
    idle(1);
    @(negedge clk);
    chk("lit_timeout_fault", 32'(fault), 32'h1);
    chk("lit_timeout_no_valid", 32'(lv), 32'h0);
    idle(3);

    do_op(1'b1, 3'b010, 32'h500, 32'h0, 5'd9, 0, 10, 32'h0);
    step();
    #2;
    rst_n = 1'b0;
    exp_req = 0; exp_stall = 0; exp_lv = 0; exp_fault = 0; exp_val = 0; exp_rd = 0;
    nxt_lv = 0; nxt_fault = 0;
    @(negedge clk);
    chk("lit_midresp_reset_value", lval, 32'h0);
    step();
    exp_lv = 0; exp_fault = 0;
    rst_n = 1'b1;
    mem_read = 1'b0;
    idle(2);
    do_op(1'b0, 3'b010, 32'h600, 32'h01020304, 5'd0, 0, 0, 32'h0);

    for (int i = 0; i < 300; i++) begin
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
            5'($urandom), $urandom_range(0, 2), $urandom_range(1, T + 2), $urandom);
      idle($urandom_range(0, 2));
    end
    idle(2);
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
